// File: rtl/picosoc_bus_arbiter.sv
// Two-master round-robin arbiter for a shared PicoRV32-style valid/ready bus.
// The arbiter completes a stalled transfer locally after TIMEOUT cycles and reports it.
module picosoc_bus_arbiter #(
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_irq,
    output logic        timeout_flag,
    output logic [31:0] timeout_addr,
    input  logic        timeout_clr
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic       TMO_EN     = (TIMEOUT != 0);
    localparam int         TMO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [7:0] TMO_LAST   = TMO_LAST_I[7:0];

    logic [0:0]  state_q, state_d;
    logic        owner_q, owner_d;   // 0 = m0, 1 = m1
    logic        last_q, last_d;     // master that completed most recently
    logic [7:0]  cnt_q, cnt_d;
    logic        irq_q, irq_d;
    logic        flag_q, flag_d;
    logic [31:0] taddr_q, taddr_d;

    logic        busy;
    logic        own_valid;
    logic        tmo_hit;
    logic [31:0] done_rdata;

    assign busy      = (state_q == ST_BUSY);
    assign own_valid = owner_q ? m1_valid : m0_valid;
    // s_ready has priority: a response arriving on the limit cycle is a normal completion.
    assign tmo_hit   = TMO_EN && busy && (cnt_q == TMO_LAST) && !s_ready;
    assign done_rdata = tmo_hit ? ERR_RDATA : s_rdata;

    assign s_valid = busy;
    assign s_addr  = busy ? (owner_q ? m1_addr  : m0_addr)  : 32'h0;
    assign s_wdata = busy ? (owner_q ? m1_wdata : m0_wdata) : 32'h0;
    assign s_wstrb = busy ? (owner_q ? m1_wstrb : m0_wstrb) : 4'h0;

    assign m0_ready = busy && !owner_q && (s_ready || tmo_hit);
    assign m1_ready = busy &&  owner_q && (s_ready || tmo_hit);
    assign m0_rdata = (busy && !owner_q) ? done_rdata : 32'h0;
    assign m1_rdata = (busy &&  owner_q) ? done_rdata : 32'h0;

    assign grant        = busy ? {owner_q, ~owner_q} : 2'b00;
    assign timeout_irq  = irq_q;
    assign timeout_flag = flag_q;
    assign timeout_addr = taddr_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        irq_d   = tmo_hit;
        flag_d  = flag_q;
        taddr_d = taddr_q;

        if (tmo_hit) begin
            flag_d  = 1'b1;
            taddr_d = s_addr;
        end else if (timeout_clr) begin
            flag_d  = 1'b0;
        end

        if (!busy) begin
            if (m0_valid || m1_valid) begin
                state_d = ST_BUSY;
                cnt_d   = 8'd0;
                if (m0_valid && m1_valid) begin
                    owner_d = ~last_q;
                end else begin
                    owner_d = m1_valid;
                end
            end
        end else if (s_ready || tmo_hit) begin
            state_d = ST_IDLE;
            last_d  = owner_q;
        end else if (!own_valid) begin
            // Master withdrew its request: abandon without counting it as served.
            state_d = ST_IDLE;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            irq_q   <= 1'b0;
            flag_q  <= 1'b0;
            taddr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
            flag_q  <= flag_d;
            taddr_q <= taddr_d;
        end
    end

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Directed bench for picosoc_bus_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_picosoc_bus_arbiter;

    localparam int          TMO = 4;
    localparam logic [31:0] ERR = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        timeout_irq, timeout_flag, timeout_clr;
    logic [31:0] timeout_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    picosoc_bus_arbiter #(.TIMEOUT(TMO), .ERR_RDATA(ERR)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_irq(timeout_irq), .timeout_flag(timeout_flag),
        .timeout_addr(timeout_addr), .timeout_clr(timeout_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: who owns the bus, how long it has waited, who was served last.
    int          mo_owner = -1;
    int          mo_wait  = 0;
    int          mo_last  = 1;
    logic        mo_irq   = 1'b0;
    logic        mo_flag  = 1'b0;
    logic [31:0] mo_taddr = 32'h0;

    initial begin
        logic        busy, tmo, ov;
        logic [31:0] e_addr, e_wdata, e_rd;
        logic [3:0]  e_wstrb;
        logic [1:0]  e_grant;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mo_owner = -1; mo_wait = 0; mo_last = 1;
                mo_irq = 1'b0; mo_flag = 1'b0; mo_taddr = 32'h0;
                chk("rst_grant", 32'(grant), 32'd0);
                chk("rst_s_valid", 32'(s_valid), 32'd0);
                chk("rst_m0_ready", 32'(m0_ready), 32'd0);
                chk("rst_m1_ready", 32'(m1_ready), 32'd0);
                chk("rst_irq", 32'(timeout_irq), 32'd0);
                chk("rst_flag", 32'(timeout_flag), 32'd0);
                chk("rst_taddr", timeout_addr, 32'd0);
            end else begin
                busy    = (mo_owner >= 0);
                ov      = (mo_owner == 1) ? m1_valid : m0_valid;
                tmo     = busy && (mo_wait == TMO - 1) && !s_ready;
                e_grant = !busy ? 2'b00 : (mo_owner == 1 ? 2'b10 : 2'b01);
                e_addr  = !busy ? 32'h0 : (mo_owner == 1 ? m1_addr  : m0_addr);
                e_wdata = !busy ? 32'h0 : (mo_owner == 1 ? m1_wdata : m0_wdata);
                e_wstrb = !busy ? 4'h0  : (mo_owner == 1 ? m1_wstrb : m0_wstrb);
                e_rd    = tmo ? ERR : s_rdata;
                chk("grant", 32'(grant), 32'(e_grant));
                chk("s_valid", 32'(s_valid), 32'(busy));
                chk("s_addr", s_addr, e_addr);
                chk("s_wdata", s_wdata, e_wdata);
                chk("s_wstrb", 32'(s_wstrb), 32'(e_wstrb));
                chk("m0_ready", 32'(m0_ready), 32'(busy && mo_owner == 0 && (s_ready || tmo)));
                chk("m1_ready", 32'(m1_ready), 32'(busy && mo_owner == 1 && (s_ready || tmo)));
                chk("m0_rdata", m0_rdata, (busy && mo_owner == 0) ? e_rd : 32'h0);
                chk("m1_rdata", m1_rdata, (busy && mo_owner == 1) ? e_rd : 32'h0);
                chk("timeout_irq", 32'(timeout_irq), 32'(mo_irq));
                chk("timeout_flag", 32'(timeout_flag), 32'(mo_flag));
                chk("timeout_addr", timeout_addr, mo_taddr);

                mo_irq = tmo;
                if (tmo) begin
                    mo_flag  = 1'b1;
                    mo_taddr = e_addr;
                end else if (timeout_clr) begin
                    mo_flag = 1'b0;
                end

                if (!busy) begin
                    if (m0_valid && m1_valid) mo_owner = (mo_last == 0) ? 1 : 0;
                    else if (m0_valid)        mo_owner = 0;
                    else if (m1_valid)        mo_owner = 1;
                    mo_wait = 0;
                end else if (s_ready || tmo) begin
                    $display("txn m%0d addr=%h wstrb=%h wdata=%h rdata=%h %s",
                             mo_owner, e_addr, e_wstrb, e_wdata, e_rd, tmo ? "timeout" : "ok");
                    mo_last  = mo_owner;
                    mo_owner = -1;
                end else if (!ov) begin
                    $display("txn m%0d addr=%h withdrawn", mo_owner, e_addr);
                    mo_owner = -1;
                end else begin
                    mo_wait++;
                end
            end
        end
    end

    logic [1:0] gnt_log[$];
    logic [1:0] exp_seq [4];
    int         n_done;

    initial begin
        resetn = 1'b1; timeout_clr = 1'b0;
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0;
        #2 resetn = 1'b0;
        step; step;
        #1;
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_flag", 32'(timeout_flag), 32'd0);
        resetn = 1'b1;

        // m0 read, slave answers on the third BUSY cycle
        step; m0_valid = 1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0;
        step; #1 chk("t027_grant", 32'(grant), 32'd1);
        chk("t027_wait_ready", 32'(m0_ready), 32'd0);
        step;
        step; s_ready = 1; s_rdata = 32'h1234_5678;
        #1 chk("t027_ready", 32'(m0_ready), 32'd1);
        chk("t027_rdata", m0_rdata, 32'h1234_5678);
        step; s_ready = 0; s_rdata = 0; m0_valid = 0;
        #1 chk("t027_grant_idle", 32'(grant), 32'd0);

        // asynchronous reset in the middle of an m1 transfer
        step; m1_valid = 1; m1_addr = 32'h0200_0000; m1_wdata = 32'hA5A5_0001; m1_wstrb = 4'hF;
        step; #1 chk("t031_grant_m1", 32'(grant), 32'd2);
        #1 resetn = 1'b0;
        #1 chk("t031_svalid_async", 32'(s_valid), 32'd0);
        chk("t031_grant_async", 32'(grant), 32'd0);
        step; step; resetn = 1'b1; m0_valid = 1; m0_addr = 32'h0000_0020; m0_wstrb = 4'h0;
        step; #1 chk("t031_tie_m0", 32'(grant), 32'd1);
        s_ready = 1; s_rdata = 32'h0000_0031;
        step; s_ready = 0; m0_valid = 0;
        step; s_ready = 1;
        step; s_ready = 0; m1_valid = 0;

        // both masters requesting continuously
        m0_valid = 1; m0_addr = 32'h0000_0030; m1_valid = 1; m1_addr = 32'h0000_0040; m1_wstrb = 4'h3;
        n_done = 0;
        for (int cyc = 0; cyc < 40 && n_done < 4; cyc++) begin
            step; s_ready = s_valid; s_rdata = 32'h100 + 32'(cyc);
            #1;
            if (s_ready) begin
                gnt_log.push_back(grant);
                n_done++;
            end
        end
        step; s_ready = 0; m0_valid = 0; m1_valid = 0;
        chk("t028_count", 32'(n_done), 32'd4);
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
        for (int i = 0; i < gnt_log.size() && i < 4; i++)
            chk("t028_order", 32'(gnt_log[i]), 32'(exp_seq[i]));

        // withdrawn request leaves round-robin history untouched (m1 served last)
        step; m0_valid = 1; m0_addr = 32'h0000_0050;
        step; #1 chk("t018_grant", 32'(grant), 32'd1);
        m0_valid = 0;
        step; #1 chk("t018_abort_idle", 32'(grant), 32'd0);
        m0_valid = 1; m0_addr = 32'h0000_0060; m1_valid = 1;
        step; #1 chk("t018_last_kept", 32'(grant), 32'd1);
        s_ready = 1;
        step; s_ready = 0; m0_valid = 0;
        step; s_ready = 1;
        step; s_ready = 0; m1_valid = 0;

        // m1 write that the slave never answers
        step; m1_valid = 1; m1_addr = 32'h0300_0000; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF;
        step; step; step; step;
        #1 chk("t029_ready", 32'(m1_ready), 32'd1);
        chk("t029_rdata", m1_rdata, 32'hFFFF_FFFF);
        chk("t029_no_irq_yet", 32'(timeout_irq), 32'd0);
        step; m1_valid = 0;
        #1 chk("t029_irq", 32'(timeout_irq), 32'd1);
        chk("t029_flag", 32'(timeout_flag), 32'd1);
        chk("t029_taddr", timeout_addr, 32'h0300_0000);
        step; #1 chk("t029_irq_once", 32'(timeout_irq), 32'd0);

        // response on exactly the limit cycle
        step; m0_valid = 1; m0_addr = 32'h0000_0070; m0_wstrb = 4'h0;
        step; step; step; step; s_ready = 1; s_rdata = 32'hCAFE_0001;
        #1 chk("t030_ready", 32'(m0_ready), 32'd1);
        chk("t030_rdata", m0_rdata, 32'hCAFE_0001);
        step; s_ready = 0; m0_valid = 0;
        #1 chk("t030_no_irq", 32'(timeout_irq), 32'd0);
        chk("t030_flag_kept", 32'(timeout_flag), 32'd1);
        chk("t030_taddr_kept", timeout_addr, 32'h0300_0000);

        // clear request coinciding with a fresh timeout
        step; m0_valid = 1; m0_addr = 32'h0000_0044;
        step; step; step; step; timeout_clr = 1;
        #1 chk("t032_ready", 32'(m0_ready), 32'd1);
        chk("t032_rdata", m0_rdata, 32'hFFFF_FFFF);
        step; m0_valid = 0;
        #1 chk("t032_flag_set", 32'(timeout_flag), 32'd1);
        chk("t032_irq", 32'(timeout_irq), 32'd1);
        chk("t032_taddr", timeout_addr, 32'h0000_0044);
        step; timeout_clr = 0;
        #1 chk("t032_flag_cleared", 32'(timeout_flag), 32'd0);

        step; step;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/picosoc_bus_arbiter.md
PICOSOC_BUS_ARBITER -- requirements
Module: picosoc_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning slave-response limit in cycles; 0 disables the timeout; legal range 0..255.
REQ-002 SHALL have parameter [31:0] ERR_RDATA, default 32'hFFFF_FFFF, meaning read data returned on a timeout completion.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports m0_valid/m1_valid  input  1  master request, held until ready (m0 = CPU, m1 = DMA).
REQ-006 SHALL have ports m0_addr/m1_addr  input  32, m0_wdata/m1_wdata  input  32, m0_wstrb/m1_wstrb  input  4  (wstrb 0 = read).
REQ-007 SHALL have ports m0_ready/m1_ready  output  1, m0_rdata/m1_rdata  output  32.
REQ-008 SHALL have ports s_valid  output  1, s_addr  output  32, s_wdata  output  32, s_wstrb  output  4  to the shared bus.
REQ-009 SHALL have ports s_ready  input  1, s_rdata  input  32  from the shared bus.
REQ-010 SHALL have port grant  output  2  one-hot owner (01 = m0, 10 = m1, 00 = none).
REQ-011 SHALL have ports timeout_irq  output  1  one-cycle pulse, timeout_flag  output  1  sticky, timeout_addr  output  32  captured address, timeout_clr  input  1  clears flag.

Function
REQ-012 SHALL implement two states, IDLE and BUSY, in a registered FSM.
REQ-013 SHALL, in IDLE with exactly one mN_valid high, grant that master and enter BUSY on the next edge.
REQ-014 SHALL, in IDLE with both valid, grant the master not served last (round-robin); last-served resets to m1, so m0 wins the first tie.
REQ-015 SHALL assert s_valid only in BUSY; s_addr/s_wdata/s_wstrb SHALL pass combinationally from the granted master in BUSY and be 0 otherwise.
REQ-016 SHALL drive the granted master's ready = s_ready and rdata = s_rdata combinationally in BUSY; the non-granted master SHALL see ready = 0, rdata = 0.
REQ-017 SHALL, on s_ready in BUSY, return to IDLE, update last-served, and clear grant; every transaction therefore has one arbitration cycle, giving minimum two-cycle occupancy.
REQ-018 SHALL, if the granted master drops valid in BUSY before ready (protocol violation), return to IDLE without completion and without updating last-served.
REQ-019 SHALL clear an 8-bit wait counter on entry to BUSY and increment it on each BUSY cycle without s_ready.
REQ-020 SHALL, when TIMEOUT != 0 and counter == TIMEOUT-1 and s_ready = 0, complete the transaction locally: granted ready = 1, rdata = ERR_RDATA, return to IDLE.
REQ-021 SHALL let s_ready win over timeout when both occur in the same cycle (normal completion, no flag).
REQ-022 SHALL, on timeout, pulse timeout_irq high for exactly the next cycle, set timeout_flag, and capture s_addr into timeout_addr; a later timeout SHALL overwrite timeout_addr.
REQ-023 SHALL clear timeout_flag on timeout_clr; simultaneous timeout and timeout_clr SHALL leave the flag set.
REQ-024 SHALL never grant a master while the other is in BUSY (no preemption).

Reset
REQ-025 SHALL, on resetn low, immediately force IDLE, grant = 00, s_valid = 0, all mN_ready = 0, timeout_irq = 0, timeout_flag = 0, timeout_addr = 0, counter = 0, last-served = m1, regardless of state.
REQ-026 SHALL resume arbitration on the first clk edge after resetn deasserts.

Verification
REQ-027 SHALL cover: m0 read addr 32'h0000_0010, s_ready after 2 BUSY cycles, s_rdata 32'h1234_5678 -> m0_ready one cycle, m0_rdata 32'h1234_5678, grant 01 then 00.
REQ-028 SHALL cover: m0 and m1 both valid continuously for 4 transactions -> grant order m0, m1, m0, m1.
REQ-029 SHALL cover: TIMEOUT = 4, m1 write to 32'h0300_0000, s_ready never -> m1_ready on the 4th BUSY cycle, timeout_irq pulse next cycle, timeout_flag = 1, timeout_addr = 32'h0300_0000.
REQ-030 SHALL cover: s_ready on exactly the timeout cycle -> normal completion with s_rdata, no irq, flag unchanged.
REQ-031 SHALL cover: resetn low mid-BUSY -> s_valid and grant 0 without a clock edge; after release m0 wins a tie.
REQ-032 SHALL cover: timeout_clr asserted with a new timeout in the same cycle -> timeout_flag remains 1.
